// File: rtl/mini_cpu_pkg.sv
// Shared types and constants for the mini CPU memory path.
package mini_cpu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } mem_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } mem_op_t;

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM: synchronous write, combinational read (the caller registers read data).
module mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int AW     = 9
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Write port
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[addr] <= din;
    end
  end

  assign dout = mem_r[addr];

endmodule

// File: rtl/mem_ctrl.sv
// Wait-stated single-word memory controller feeding the MDR.
// Optional out-of-range fault reporting is enabled by defining ADDR_FAULT_EN.
module mem_ctrl #(
  parameter int DATA_W      = mini_cpu_pkg::DATA_W,
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 2
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] Mdatain,
  output logic              mem_done,
  output logic              busy,
  output logic              fault
);

  import mini_cpu_pkg::*;

  localparam int          RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]  WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  mem_state_t        state_r, next_state_s;
  logic [3:0]        cnt_r, cnt_nxt_s;
  logic              accept_s;
  mem_op_t           op_r;
  logic [RAM_AW-1:0] ram_addr_r;
  logic [DATA_W-1:0] din_r;
  logic              inrange_r;
  logic [DATA_W-1:0] mdatain_r, md_nxt_s;
  logic              done_r, busy_r, fault_r, fault_nxt_s;
  logic              ram_we_s;
  logic [DATA_W-1:0] ram_dout_s;

  // Next-state and wait-counter logic
  always_comb begin
    next_state_s = state_r;
    cnt_nxt_s    = cnt_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (read || write) begin
          accept_s = 1'b1;
          if (WAIT_STATES > 0) begin
            next_state_s = WAIT;
          end else begin
            next_state_s = ACCESS;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == WS_LAST) begin
          next_state_s = ACCESS;
          cnt_nxt_s    = 4'd0;
        end else begin
          cnt_nxt_s = cnt_r + 4'd1;
        end
      end
      ACCESS:  next_state_s = DONE;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Access-cycle data path: RAM write enable, read data and fault
  always_comb begin
    ram_we_s    = 1'b0;
    md_nxt_s    = mdatain_r;
    fault_nxt_s = 1'b0;
    if (state_r == ACCESS) begin
      if (op_r == OP_WR) begin
        ram_we_s = inrange_r;
      end else if (inrange_r) begin
        md_nxt_s = ram_dout_s;
      end else begin
`ifdef ADDR_FAULT_EN
        md_nxt_s = mdatain_r;
`else
        md_nxt_s = '0;
`endif
      end
`ifdef ADDR_FAULT_EN
      fault_nxt_s = ~inrange_r;
`else
      fault_nxt_s = 1'b0;
`endif
    end else begin
      ram_we_s = 1'b0;
    end
  end

  // FSM state and registered outputs; clear aborts any access in flight
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      fault_r   <= 1'b0;
      mdatain_r <= '0;
    end else begin
      state_r   <= next_state_s;
      cnt_r     <= cnt_nxt_s;
      busy_r    <= (next_state_s != IDLE);
      done_r    <= (next_state_s == DONE);
      fault_r   <= fault_nxt_s;
      mdatain_r <= md_nxt_s;
    end
  end

  // Request capture at the accepting edge; later input changes are ignored
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      op_r       <= OP_RD;
      ram_addr_r <= '0;
      din_r      <= '0;
      inrange_r  <= 1'b0;
    end else if (accept_s) begin
      op_r       <= write ? OP_WR : OP_RD;
      ram_addr_r <= addr[RAM_AW-1:0];
      din_r      <= data_in;
      inrange_r  <= ({1'b0, addr} < DEPTH_V);
    end
  end

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAM_AW)
  ) u_mem (
    .clock (clock),
    .we    (ram_we_s),
    .addr  (ram_addr_r),
    .din   (din_r),
    .dout  (ram_dout_s)
  );

  assign Mdatain  = mdatain_r;
  assign mem_done = done_r;
  assign busy     = busy_r;
  assign fault    = fault_r;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: instance a (WAIT_STATES=2, DEPTH=256), instance b (WAIT_STATES=0).
module tb_mem_ctrl;

  localparam int WS_A = 2;
  localparam int WS_B = 0;
`ifdef ADDR_FAULT_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  typedef struct {
    logic [31:0] md;
    logic        f;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  logic        a_clear, a_read, a_write, a_done, a_busy, a_fault;
  logic [8:0]  a_addr;
  logic [31:0] a_din, a_md;
  logic        b_clear, b_read, b_write, b_done, b_busy, b_fault;
  logic [8:0]  b_addr;
  logic [31:0] b_din, b_md;

  mem_ctrl #(.DATA_W(32), .ADDR_W(9), .DEPTH(256), .WAIT_STATES(WS_A)) dut_a (
    .clock(clk), .clear(a_clear), .read(a_read), .write(a_write), .addr(a_addr),
    .data_in(a_din), .Mdatain(a_md), .mem_done(a_done), .busy(a_busy), .fault(a_fault)
  );

  mem_ctrl #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .WAIT_STATES(WS_B)) dut_b (
    .clock(clk), .clear(b_clear), .read(b_read), .write(b_write), .addr(b_addr),
    .data_in(b_din), .Mdatain(b_md), .mem_done(b_done), .busy(b_busy), .fault(b_fault)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive(input bit b, input logic rd, input logic wr, input logic [8:0] ad,
                       input logic [31:0] d);
    if (b) begin
      b_read = rd; b_write = wr; b_addr = ad; b_din = d;
    end else begin
      a_read = rd; a_write = wr; a_addr = ad; a_din = d;
    end
  endtask

  // One request: push expectation, scramble inputs after sampling, check busy window.
  task automatic op(input bit b, input logic rd, input logic wr, input logic [8:0] ad,
                    input logic [31:0] d, input logic [31:0] exp_md, input logic exp_f,
                    input bit pulse);
    int ws;
    int t0;
    exp_t e;
    ws = b ? WS_B : WS_A;
    @(negedge clk);
    t0 = cyc;
    drive(b, rd, wr, ad, d);
    e.md = exp_md; e.f = exp_f; e.cyc = t0 + ws + 2;
    if (b) q_b.push_back(e);
    else q_a.push_back(e);
    for (int k = 1; k <= ws + 3; k++) begin
      @(negedge clk);
      if (k == 1) drive(b, pulse, 1'b0, pulse ? 9'h020 : 9'($urandom()), $urandom());
      else drive(b, 1'b0, 1'b0, 9'($urandom()), $urandom());
      chk(b ? "b_busy" : "a_busy", b ? b_busy : a_busy, (k <= ws + 2) ? 32'd1 : 32'd0);
    end
    chk(b ? "b_done_seen" : "a_done_seen", b ? q_b.size() : q_a.size(), 32'd0);
  endtask

  // Monitor for instance a
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_fault && !a_done) begin
      n_chk++; n_fail++;
      $display("FAIL a_fault_stray: fault=1 without mem_done, expected 0 (cycle %0d)", cyc);
    end
    if (a_done) begin
      if (q_a.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL a_unexpected_done: mem_done=1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = q_a.pop_front();
        chk("a_mdatain", a_md, e.md);
        chk("a_fault", {31'd0, a_fault}, {31'd0, e.f});
        chk("a_done_cycle", cyc, e.cyc);
        chk("a_busy_at_done", {31'd0, a_busy}, 32'd1);
      end
    end
  end

  // Monitor for instance b
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_done) begin
      if (q_b.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL b_unexpected_done: mem_done=1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = q_b.pop_front();
        chk("b_mdatain", b_md, e.md);
        chk("b_fault", {31'd0, b_fault}, {31'd0, e.f});
        chk("b_done_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    exp_t e;
    logic [31:0] md_oor;
    a_clear = 1'b1; b_clear = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 9'h000, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 9'h000, 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_mdatain", a_md, 32'h0);
    chk("rst_done", {31'd0, a_done}, 32'd0);
    chk("rst_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_fault", {31'd0, a_fault}, 32'd0);
    a_clear = 1'b0; b_clear = 1'b0;

    op(1'b0, 1'b0, 1'b1, 9'h005, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0);
    op(1'b0, 1'b1, 1'b0, 9'h005, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0);
    op(1'b0, 1'b1, 1'b1, 9'h010, 32'h12345678, 32'hDEADBEEF, 1'b0, 1'b0);
    op(1'b0, 1'b1, 1'b0, 9'h010, 32'h0,        32'h12345678, 1'b0, 1'b0);
    op(1'b0, 1'b0, 1'b1, 9'h020, 32'h11112222, 32'h12345678, 1'b0, 1'b0);
    op(1'b0, 1'b0, 1'b1, 9'h0FF, 32'h77777777, 32'h12345678, 1'b0, 1'b0);
    op(1'b0, 1'b1, 1'b0, 9'h005, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1);

    md_oor = FEAT ? 32'hDEADBEEF : 32'h0;
    op(1'b0, 1'b1, 1'b0, 9'h1FF, 32'h0,        md_oor,       FEAT, 1'b0);
    op(1'b0, 1'b0, 1'b1, 9'h1FF, 32'h0BADF00D, md_oor,       FEAT, 1'b0);
    op(1'b0, 1'b1, 1'b0, 9'h0FF, 32'h0,        32'h77777777, 1'b0, 1'b0);

    // Request held high: second sample one IDLE cycle after DONE
    @(negedge clk);
    t0 = cyc;
    drive(1'b0, 1'b1, 1'b0, 9'h010, 32'h0);
    e.md = 32'h12345678; e.f = 1'b0; e.cyc = t0 + WS_A + 2;
    q_a.push_back(e);
    e.cyc = t0 + 2 * WS_A + 5;
    q_a.push_back(e);
    repeat (WS_A + 4) @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 9'h000, 32'h0);
    repeat (WS_A + 3) @(negedge clk);
    chk("a_b2b_both_done", q_a.size(), 32'd0);

    // Clear during WAIT of a write aborts it
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 9'h005, 32'hCAFEF00D);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 9'h000, 32'h0);
    a_clear = 1'b1;
    #1;
    chk("abort_mdatain", a_md, 32'h0);
    chk("abort_done", {31'd0, a_done}, 32'd0);
    chk("abort_busy", {31'd0, a_busy}, 32'd0);
    chk("abort_fault", {31'd0, a_fault}, 32'd0);
    @(negedge clk);
    a_clear = 1'b0;
    repeat (5) @(negedge clk);
    op(1'b0, 1'b1, 1'b0, 9'h005, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

    op(1'b1, 1'b0, 1'b1, 9'h001, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0);
    op(1'b1, 1'b1, 1'b0, 9'h001, 32'h0,        32'hA5A5A5A5, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    chk("a_queue_empty", q_a.size(), 32'd0);
    chk("b_queue_empty", q_b.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
